// File: rtl/i2c_slave_regfile.sv
// 7-bit I2C target exposing NUM_REGS x 8-bit registers; first write byte sets an auto-incrementing pointer.
// Bus events lag the pads by 2+FILTER_LEN clocks; a written byte reaches regs_flat one clock after wr_strobe.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         NUM_REGS   = 4,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] RESET_VAL  = 8'h00,
  localparam int        PTR_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK
  } state_t;

  // Index 1 carries SCL, index 0 carries SDA.
  logic [1:0] sync1, sync2, filt, prev;
  logic [3:0] cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      filt  <= 2'b11;
      prev  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {scl_i, sda_i};
      sync2 <= sync1;
      prev  <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (cnt[i] == 4'(FILTER_LEN - 1)) begin
            filt[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_p    = prev[1];
  assign sda_p    = prev[0];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

  state_t           state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             byte_done, byte_done_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       rd_shift, rd_shift_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             rw, rw_n;
  logic             sda_oe_n;
  logic             wr_strobe_n;
  logic [PTR_W-1:0] wr_index_n;
  logic [7:0]       wr_dat, wr_dat_n;
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       rd_byte;

  assign rd_byte = regs[ptr];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      shift     <= '0;
      rd_shift  <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_dat    <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_done <= byte_done_n;
      shift     <= shift_n;
      rd_shift  <= rd_shift_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      sda_oe    <= sda_oe_n;
      wr_strobe <= wr_strobe_n;
      wr_index  <= wr_index_n;
      wr_dat    <= wr_dat_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_done_n = byte_done;
    shift_n     = shift;
    rd_shift_n  = rd_shift;
    ptr_n       = ptr;
    rw_n        = rw;
    sda_oe_n    = sda_oe;
    wr_strobe_n = 1'b0;
    wr_index_n  = wr_index;
    wr_dat_n    = wr_dat;

    if (start_c) begin
      state_n     = ADDR;
      sda_oe_n    = 1'b0;
      bit_cnt_n   = '0;
      byte_done_n = 1'b0;
    end else if (stop_c) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_f};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_n = 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            if (state == ADDR) begin
              if (shift[7:1] == SLAVE_ADDR) begin
                sda_oe_n = 1'b1;
                rw_n     = shift[0];
                state_n  = ADDR_ACK;
              end else begin
                state_n = IDLE;
              end
            end else if (state == PTR) begin
              ptr_n    = shift[PTR_W-1:0];
              sda_oe_n = 1'b1;
              state_n  = PTR_ACK;
            end else begin
              wr_strobe_n = 1'b1;
              wr_index_n  = ptr;
              wr_dat_n    = shift;
              ptr_n       = ptr + 1'b1;
              sda_oe_n    = 1'b1;
              state_n     = WACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              rd_shift_n = rd_byte;
              sda_oe_n   = ~rd_byte[7];
              bit_cnt_n  = '0;
              state_n    = RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = PTR;
            end
          end
        end
        PTR_ACK, WACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              ptr_n     = ptr + 1'b1;
              bit_cnt_n = '0;
              state_n   = RACK;
            end else begin
              sda_oe_n   = ~rd_shift[6];
              rd_shift_n = {rd_shift[6:0], 1'b0};
              bit_cnt_n  = bit_cnt + 3'd1;
            end
          end
        end
        RACK: begin
          // A NACK ends the read as soon as it is sampled.
          if (scl_rise && sda_f) begin
            state_n = IDLE;
          end else if (scl_fall) begin
            rd_shift_n = rd_byte;
            sda_oe_n   = ~rd_byte[7];
            bit_cnt_n  = '0;
            state_n    = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else if (wr_strobe) begin
      regs[wr_index] <= wr_dat;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bus-level master with a register/pointer model; monitors score ACK/read slots and write strobes.
module tb_i2c_slave_regfile;
  localparam logic [6:0] ADDR = 7'h55;
  localparam int         NR   = 4;
  localparam int         FL   = 3;
  localparam logic [7:0] RV   = 8'h00;
  localparam int         Q    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [NR*8-1:0] regs_flat;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;
  wire         sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .SLAVE_ADDR(ADDR), .NUM_REGS(NR), .FILTER_LEN(FL), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  typedef struct {
    int         idx;
    logic [7:0] dat;
  } wr_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model [NR];
  int         mptr = 0;
  logic       exp_sda_q [$];
  wr_t        exp_wr_q [$];
  logic [7:0] pend [$];
  logic       slave_slot = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Slave-driven bit slots, sampled mid SCL-high.
  initial forever begin
    @(posedge scl_m);
    repeat (Q) @(negedge clk);
    if (slave_slot) begin
      if (exp_sda_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL sda_slot: slot with no expectation, line=%0b", sda_line);
      end else begin
        check("sda_slot", 32'(sda_line), 32'(exp_sda_q.pop_front()));
      end
    end
  end

  // Write strobes against expected commits.
  initial forever begin
    @(negedge clk);
    if (wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL wr_strobe: unexpected strobe index=%0d", wr_index);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("wr_index", 32'(wr_index), 32'(e.idx));
        @(negedge clk);
        check("wr_strobe_width", 32'(wr_strobe), 32'(0));
        check("wr_data", 32'(regs_flat[8*e.idx +: 8]), 32'(e.dat));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b, input logic slave, input logic exp);
    wclk(Q);
    sda_m = b;
    wclk(Q);
    if (slave) begin
      exp_sda_q.push_back(exp);
      slave_slot = 1'b1;
    end
    scl_m = 1'b1;
    wclk(2*Q);
    scl_m = 1'b0;
    slave_slot = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_line);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, ack_line);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, 1'b1, exp[i]);
    send_bit(nack, 1'b0, 1'b0);
  endtask

  task automatic start_c();
    if (!scl_m) begin
      wclk(Q); sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q);
    end
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wclk(Q); sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b1; wclk(2*Q);
  endtask

  task automatic check_regs();
    for (int k = 0; k < NR; k++) check("reg_value", 32'(regs_flat[8*k +: 8]), 32'(model[k]));
  endtask

  // Sets the pointer and writes every byte queued in pend; hold skips the STOP.
  task automatic do_write(input logic [7:0] p, input logic hold);
    logic [7:0] d;
    start_c();
    send_byte({ADDR, 1'b0}, 1'b0);
    check("busy_in_txn", 32'(busy), 32'(1));
    send_byte(p, 1'b0);
    mptr = int'(p) % NR;
    while (pend.size() > 0) begin
      d = pend.pop_front();
      exp_wr_q.push_back('{mptr, d});
      model[mptr] = d;
      send_byte(d, 1'b0);
      mptr = (mptr + 1) % NR;
    end
    if (!hold) begin
      stop_c();
      check("busy_after_stop", 32'(busy), 32'(0));
      check_regs();
    end
  endtask

  task automatic do_read(input int n);
    start_c();
    send_byte({ADDR, 1'b1}, 1'b0);
    for (int k = 0; k < n; k++) begin
      read_byte(model[mptr], k == n - 1);
      mptr = (mptr + 1) % NR;
    end
    check("busy_after_nack", 32'(busy), 32'(0));
    check("oe_after_nack", 32'(sda_oe), 32'(0));
    stop_c();
  endtask

  initial begin
    logic       seen;
    logic [7:0] p8;
    logic [7:0] v;
    for (int k = 0; k < NR; k++) model[k] = RV;

    wclk(5);
    rst = 1'b0;
    wclk(10);
    check("reset_sda_oe", 32'(sda_oe), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_wr_strobe", 32'(wr_strobe), 32'(0));
    check("reset_wr_index", 32'(wr_index), 32'(0));
    check_regs();

    // Two-byte write from pointer 1.
    pend.push_back(8'h3C);
    pend.push_back(8'h7E);
    do_write(8'h01, 1'b0);

    // Pointer 3, repeated START, read two bytes wrapping to reg0.
    pend.push_back(8'($urandom));
    do_write(8'h03, 1'b0);
    do_write(8'h03, 1'b1);
    do_read(2);

    // Address mismatch: no ACK and following bytes ignored.
    start_c();
    send_byte(8'hA8, 1'b1);
    check("busy_mismatch", 32'(busy), 32'(0));
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    stop_c();
    check_regs();

    // Repeated START after four data bits discards the partial byte.
    start_c();
    send_byte({ADDR, 1'b0}, 1'b0);
    p8 = 8'($urandom);
    send_byte(p8, 1'b0);
    mptr = int'(p8) % NR;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    pend.push_back(8'($urandom));
    do_write(8'($urandom), 1'b0);

    // Glitch rejection on SDA while SCL is high.
    wclk(4*Q);
    seen = 1'b0;
    sda_m = 1'b0;
    wclk(FL - 1);
    sda_m = 1'b1;
    for (int i = 0; i < 20; i++) begin wclk(1); seen |= busy; end
    check("glitch_short_busy", 32'(seen), 32'(0));
    sda_m = 1'b0;
    for (int i = 0; i < FL + 1; i++) begin wclk(1); seen |= busy; end
    sda_m = 1'b1;
    for (int i = 0; i < 20; i++) begin wclk(1); seen |= busy; end
    check("glitch_long_start", 32'(seen), 32'(1));
    check("glitch_long_idle", 32'(busy), 32'(0));

    // Randomised writes and reads.
    for (int t = 0; t < 8; t++) begin
      p8 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) pend.push_back(8'($urandom));
        do_write(p8, 1'b0);
      end else begin
        do_write(p8, 1'b1);
        do_read(int'($urandom_range(1, 4)));
      end
    end

    // Reset during read bit 5 while the target pulls SDA low.
    v = 8'($urandom) & 8'hDF;
    pend.push_back(v);
    do_write(8'h02, 1'b0);
    do_write(8'h02, 1'b1);
    start_c();
    send_byte({ADDR, 1'b1}, 1'b0);
    send_bit(1'b1, 1'b1, v[7]);
    send_bit(1'b1, 1'b1, v[6]);
    wclk(Q);
    check("oe_before_rst", 32'(sda_oe), 32'(1));
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    check("oe_after_rst", 32'(sda_oe), 32'(0));
    check("busy_after_rst", 32'(busy), 32'(0));
    for (int k = 0; k < NR; k++) model[k] = RV;
    mptr = 0;
    check_regs();
    wclk(Q);
    sda_m = 1'b1;
    scl_m = 1'b1;
    wclk(4*Q);
    pend.push_back(8'($urandom));
    pend.push_back(8'($urandom));
    do_write(8'($urandom), 1'b0);
    do_write(8'h00, 1'b1);
    do_read(NR);

    wclk(4*Q);
    check("pending_wr", 32'(exp_wr_q.size()), 32'(0));
    check("pending_sda", 32'(exp_sda_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
